inst_mem_loader: RTL and testbench

Instruction memory with a built-in byte-stream loader, sitting directly upstream of the single-cycle CPU's instruction port. After reset it holds the CPU in reset while a program arrives byte-by-byte over a valid/ready stream. It packs the bytes big-endian into 32-bit words and writes them to a word-addressed RAM. Once the stream ends, it releases the CPU and serves `inst_data` for each `inst_addr`, with one-cycle registered latency.

---
 rtl/inst_mem_loader.sv | 142 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction RAM with a byte-stream program loader in front of it.
// Holds the CPU in reset while a big-endian byte stream is packed into words.
module inst_mem_loader #(
    parameter int AW            = 6,
    parameter bit LOAD_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_words,
    output logic          ld_err,
    output logic          cpu_rst,
    input  logic          inst_ren,
    input  logic [31:0]   inst_addr,
    output logic [31:0]   inst_data
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam state_t RST_STATE = LOAD_ON_RESET ? S_LOAD : S_RUN;

    state_t      state;
    logic [1:0]  lane;
    logic [23:0] pend;
    logic [31:0] mem [DEPTH];

    logic        xfer;
    logic        wr_fire;
    logic        room;
    logic        addr_high;
    logic [1:0]  addr_lsb_unused;

    function automatic logic [31:0] pack_word(input logic [23:0] p,
                                              input logic [1:0]  l,
                                              input logic [7:0]  b);
        logic [31:0] w;
        case (l)
            2'd0:    w = {b, 24'h000000};
            2'd1:    w = {p[23:16], b, 16'h0000};
            2'd2:    w = {p[23:8], b, 8'h00};
            default: w = {p, b};
        endcase
        return w;
    endfunction

    assign xfer            = ld_valid & ld_ready;
    assign wr_fire         = xfer & ((lane == 2'd3) | ld_last);
    // ld_words doubles as the write pointer; its top bit means the RAM is full.
    assign room            = ~ld_words[AW];
    assign addr_high       = |inst_addr[31:AW+2];
    assign addr_lsb_unused = inst_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            lane     <= 2'd0;
            ld_words <= '0;
            ld_err   <= 1'b0;
            ld_ready <= LOAD_ON_RESET;
            cpu_rst  <= LOAD_ON_RESET;
        end else begin
            case (state)
                S_LOAD: begin
                    if (xfer) begin
                        lane <= lane + 2'd1;
                        if (wr_fire) begin
                            if (room)
                                ld_words <= ld_words + 1'b1;
                            else
                                ld_err <= 1'b1;
                        end
                        if (ld_last) begin
                            if (lane != 2'd3)
                                ld_err <= 1'b1;
                            lane     <= 2'd0;
                            state    <= S_FLUSH;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    state   <= S_RUN;
                    cpu_rst <= 1'b0;
                end
                S_RUN: begin
                    if (ld_start) begin
                        state    <= S_LOAD;
                        lane     <= 2'd0;
                        ld_words <= '0;
                        ld_err   <= 1'b0;
                        ld_ready <= 1'b1;
                        cpu_rst  <= 1'b1;
                    end
                end
                default: begin
                    state    <= RST_STATE;
                    lane     <= 2'd0;
                    ld_ready <= LOAD_ON_RESET;
                    cpu_rst  <= LOAD_ON_RESET;
                end
            endcase
        end
    end

    // Assembly register for lanes 0..2; a reset drops it because lane returns to 0.
    always_ff @(posedge clk) begin
        if (xfer) begin
            case (lane)
                2'd0:    pend[23:16] <= ld_byte;
                2'd1:    pend[15:8]  <= ld_byte;
                2'd2:    pend[7:0]   <= ld_byte;
                default: pend        <= pend;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && room)
            mem[ld_words[AW-1:0]] <= pack_word(pend, lane, ld_byte);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_data <= 32'h0000_0000;
        end else if (state != S_RUN) begin
            inst_data <= 32'h0000_0000;
        end else if (inst_ren) begin
            inst_data <= addr_high ? 32'h0000_0000 : mem[inst_addr[AW+1:2]];
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two instances (AW=6 and AW=2) share one stimulus
// stream; read responses are predicted by a word-level model and scoreboarded.
module tb_inst_mem_loader;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] e6;
        bit          c6;
        logic [31:0] e2;
        bit          c2;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start, ld_valid, ld_last, inst_ren;
    logic [7:0]  ld_byte;
    logic [31:0] inst_addr;

    logic        rdy6, err6, cpu6, rdy2, err2, cpu2;
    logic [6:0]  words6;
    logic [2:0]  words2;
    logic [31:0] data6, data2;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    logic [31:0] m6 [64];
    bit          k6 [64];
    logic [31:0] m2 [4];
    bit          k2 [4];
    int          ew6, ew2;
    bit          ee6, ee2;
    logic [31:0] last6, last2;
    bit          lk6, lk2;

    rsp_t sb_q [$];

    logic [7:0] prog1 [8] = '{8'h8C, 8'h01, 8'h00, 8'h14, 8'h8C, 8'h02, 8'h00, 8'h18};
    logic [7:0] prog2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    logic [7:0] prog4 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    inst_mem_loader #(.AW(6), .LOAD_ON_RESET(1'b1)) u6 (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(rdy6), .ld_words(words6),
        .ld_err(err6), .cpu_rst(cpu6), .inst_ren(inst_ren), .inst_addr(inst_addr),
        .inst_data(data6)
    );

    inst_mem_loader #(.AW(2), .LOAD_ON_RESET(1'b1)) u2 (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(rdy2), .ld_words(words2),
        .ld_err(err2), .cpu_rst(cpu2), .inst_ren(inst_ren), .inst_addr(inst_addr),
        .inst_data(data2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc_n) begin
            rsp_t r;
            r = sb_q.pop_front();
            if (r.c6) chk($sformatf("read aw6 addr=%h", r.addr), data6, r.e6);
            if (r.c2) chk($sformatf("read aw2 addr=%h", r.addr), data2, r.e2);
        end
    end

    // Word-level view of a completed load: zero-filled big-endian words, truncated at capacity.
    task automatic model_load(input bq_t b);
        int nw;
        logic [31:0] w;
        nw = (b.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < b.size())
                    w = w | (32'(b[4 * i + k]) << (24 - 8 * k));
            if (i < 64) begin m6[i] = w; k6[i] = 1'b1; end
            if (i < 4)  begin m2[i] = w; k2[i] = 1'b1; end
        end
        ew6 = (nw > 64) ? 64 : nw;
        ew2 = (nw > 4) ? 4 : nw;
        ee6 = (b.size() % 4 != 0) || (nw > 64);
        ee2 = (b.size() % 4 != 0) || (nw > 4);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit noise);
        int guard;
        while ($urandom_range(0, 3) == 0) begin
            ld_valid  = 1'b0;
            ld_byte   = 8'($urandom);
            ld_last   = 1'($urandom_range(0, 1));
            ld_start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            inst_ren  = 1'($urandom_range(0, 1));
            inst_addr = $urandom;
            tick();
        end
        ld_start  = 1'b0;
        ld_valid  = 1'b1;
        ld_byte   = b;
        ld_last   = last;
        inst_ren  = 1'($urandom_range(0, 1));
        inst_addr = $urandom;
        guard = 0;
        while (!(rdy6 && rdy2)) begin
            guard++;
            if (guard > 8) begin
                checks++;
                errors++;
                $display("FAIL ld_ready wait: got %b/%b want 1/1", rdy6, rdy2);
                break;
            end
            tick();
        end
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        inst_ren = 1'b0;
    endtask

    task automatic load_prog(input bq_t b, input bit noise);
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], i == b.size() - 1, noise);
        inst_ren = 1'b0;
        chk("cpu_rst aw6 in flush", 32'(cpu6), 32'd1);
        chk("cpu_rst aw2 in flush", 32'(cpu2), 32'd1);
        chk("ld_ready aw6 in flush", 32'(rdy6), 32'd0);
        chk("inst_data aw6 during load", data6, 32'h0);
        tick();
        chk("cpu_rst aw6 in run", 32'(cpu6), 32'd0);
        chk("cpu_rst aw2 in run", 32'(cpu2), 32'd0);
        model_load(b);
        chk("ld_words aw6", 32'(words6), 32'(ew6));
        chk("ld_err aw6", 32'(err6), 32'(ee6));
        chk("ld_words aw2", 32'(words2), 32'(ew2));
        chk("ld_err aw2", 32'(err2), 32'(ee2));
        last6 = 32'h0; lk6 = 1'b1;
        last2 = 32'h0; lk2 = 1'b1;
    endtask

    task automatic start_reload();
        ld_start = 1'b1;
        inst_ren = 1'b0;
        tick();
        ld_start = 1'b0;
        chk("cpu_rst aw6 after ld_start", 32'(cpu6), 32'd1);
        chk("ld_ready aw6 after ld_start", 32'(rdy6), 32'd1);
        chk("ld_ready aw2 after ld_start", 32'(rdy2), 32'd1);
        chk("ld_words aw6 after ld_start", 32'(words6), 32'd0);
        chk("ld_err aw6 after ld_start", 32'(err6), 32'd0);
        tick();
        chk("inst_data aw6 cleared by reload", data6, 32'h0);
        chk("inst_data aw2 cleared by reload", data2, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input bit en);
        rsp_t r;
        r.due  = cyc_n + 1;
        r.addr = a;
        if (en) begin
            if ((a >> 8) != 0) begin r.e6 = 32'h0; r.c6 = 1'b1; end
            else begin r.e6 = m6[(a >> 2) % 64]; r.c6 = k6[(a >> 2) % 64]; end
            if ((a >> 4) != 0) begin r.e2 = 32'h0; r.c2 = 1'b1; end
            else begin r.e2 = m2[(a >> 2) % 4]; r.c2 = k2[(a >> 2) % 4]; end
            last6 = r.e6; lk6 = r.c6;
            last2 = r.e2; lk2 = r.c2;
        end else begin
            r.e6 = last6; r.c6 = lk6;
            r.e2 = last2; r.c2 = lk2;
        end
        inst_ren  = en;
        inst_addr = a;
        sb_q.push_back(r);
        tick();
        inst_ren = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({"inst_data aw6 ", tag}, data6, 32'h0);
        chk({"ld_words aw6 ", tag}, 32'(words6), 32'd0);
        chk({"ld_err aw6 ", tag}, 32'(err6), 32'd0);
        chk({"cpu_rst aw6 ", tag}, 32'(cpu6), 32'd1);
        chk({"ld_ready aw6 ", tag}, 32'(rdy6), 32'd1);
        chk({"ld_ready aw2 ", tag}, 32'(rdy2), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bq_t p;
        int  nw;
        logic [31:0] a;
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h0;
        ld_last = 1'b0; inst_ren = 1'b0; inst_addr = 32'h0;
        for (int i = 0; i < 64; i++) k6[i] = 1'b0;
        for (int i = 0; i < 4; i++)  k2[i] = 1'b0;
        last6 = 32'h0; last2 = 32'h0; lk6 = 1'b1; lk2 = 1'b1;
        repeat (2) tick();
        check_reset_state("at reset");
        rst = 1'b0;
        tick();

        p = {};
        foreach (prog1[i]) p.push_back(prog1[i]);
        load_prog(p, 1'b0);
        rd(32'h0000_0000, 1'b1);
        rd(32'h0000_0004, 1'b1);
        rd(32'h0000_0102, 1'b1);
        rd(32'h0000_0002, 1'b1);
        rd(32'h0000_0007, 1'b1);
        rd($urandom, 1'b0);
        rd(32'h0000_1000, 1'b1);

        start_reload();
        p = {};
        foreach (prog2[i]) p.push_back(prog2[i]);
        load_prog(p, 1'b0);
        rd(32'h0000_0004, 1'b1);
        rd(32'h0000_0000, 1'b1);

        start_reload();
        p = {};
        repeat (20) p.push_back(8'($urandom));
        load_prog(p, 1'b0);
        for (int i = 0; i < 5; i++) rd(32'(4 * i), 1'b1);

        start_reload();
        p = {};
        repeat (7) p.push_back(8'($urandom));
        for (int i = 0; i < 7; i++) send_byte(p[i], 1'b0, 1'b0);
        m6[0] = {p[0], p[1], p[2], p[3]}; k6[0] = 1'b1;
        m2[0] = {p[0], p[1], p[2], p[3]}; k2[0] = 1'b1;
        #2 rst = 1'b1;
        tick();
        check_reset_state("after mid-load reset");
        rst = 1'b0;
        tick();
        p = {};
        foreach (prog4[i]) p.push_back(prog4[i]);
        load_prog(p, 1'b0);
        rd(32'h0000_0000, 1'b1);
        rd(32'h0000_0004, 1'b1);

        repeat (6) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
            ld_last  = 1'($urandom_range(0, 1));
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ld_words aw6 after idle traffic", 32'(words6), 32'(ew6));
        chk("ld_err aw6 after idle traffic", 32'(err6), 32'(ee6));
        rd(32'h0000_0000, 1'b1);

        repeat (5) begin
            start_reload();
            p = {};
            repeat ($urandom_range(1, 24)) p.push_back(8'($urandom));
            load_prog(p, 1'b1);
            nw = (p.size() + 3) / 4;
            repeat (12) begin
                a = 32'(4 * $urandom_range(0, nw - 1)) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 4) == 0) a = a | (32'h1 << $urandom_range(8, 31));
                if ($urandom_range(0, 4) == 0) rd($urandom, 1'b0);
                else rd(a, 1'b1);
            end
        end

        repeat (3) tick();
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
